// File: rtl/multicast_fanout_if.sv
// Upstream/downstream bundle for the multicast replication stage: one flit+mask
// in, FAN_OUT per-port flit outputs with independent valid/avail handshakes.
interface multicast_fanout_if #(
   parameter int FAN_OUT      = 6,
   parameter int FLIT_CHILD_W = 85
);
   // Handshake rule for every channel: a transfer happens on a rising edge where
   // valid and avail are both 1; avail with valid low has no effect.
   logic [FLIT_CHILD_W-1:0]         in;
   logic [FAN_OUT-1:0]              in_mask;
   logic                            in_valid;
   logic                            in_avail;
   logic [FLIT_CHILD_W*FAN_OUT-1:0] out;
   logic [FAN_OUT-1:0]              out_valid;
   logic [FAN_OUT-1:0]              out_avail;
   logic [7:0]                      drop_cnt;
   logic [1:0]                      dbg_occupancy;
   logic [FAN_OUT-1:0]              dbg_pending;

   modport slave (
      input  in, in_mask, in_valid, out_avail,
      output in_avail, out, out_valid, drop_cnt, dbg_occupancy, dbg_pending
   );

   modport master (
      output in, in_mask, in_valid, out_avail,
      input  in_avail, out, out_valid, drop_cnt, dbg_occupancy, dbg_pending
   );
endinterface

// File: rtl/multicast_fanout.sv
// Multicast replication stage: a 2-entry {flit, mask} FIFO whose head is offered
// to every masked port and retires once each of those ports has taken it.
module multicast_fanout #(
   parameter int FAN_OUT     = 6,
   parameter int ValidBitPos = 81,
   parameter int lg_numprocs = 3
) (
   input  logic clk,
   input  logic rst,
   multicast_fanout_if.slave bus
);
   localparam int FlitWidth      = ValidBitPos + 1;
   localparam int ChildrenWidth  = lg_numprocs;
   localparam int FlitChildWidth = FlitWidth + ChildrenWidth;

   logic [FlitChildWidth-1:0] flit_q [2];
   logic [FAN_OUT-1:0]        mask_q [2];
   logic                      rd_ptr_q, wr_ptr_q;
   logic [1:0]                occ_q, occ_d;
   logic [FAN_OUT-1:0]        pending_q, pending_d;
   logic [7:0]                drop_cnt_q, drop_cnt_d;

   logic                      head_present;
   logic                      accept, push, drop, retire;
   logic [FAN_OUT-1:0]        out_valid_w, fire;

   assign head_present = (occ_q != 2'd0);
   assign bus.in_avail = (occ_q != 2'd2);
   assign accept       = bus.in_valid & bus.in_avail;
   assign push         = accept & (|bus.in_mask);
   assign drop         = accept & ~(|bus.in_mask);

   assign out_valid_w  = {FAN_OUT{head_present}} & pending_q;
   assign fire         = out_valid_w & bus.out_avail;
   assign retire       = head_present & ((pending_q & ~fire) == '0);

   assign bus.out_valid     = out_valid_w;
   assign bus.out           = head_present ? {FAN_OUT{flit_q[rd_ptr_q]}}
                                           : '0;
   assign bus.drop_cnt      = drop_cnt_q;
   assign bus.dbg_occupancy = occ_q;
   assign bus.dbg_pending   = pending_q;

   always_comb begin
      pending_d  = pending_q & ~fire;
      occ_d      = occ_q + {1'b0, push} - {1'b0, retire};
      drop_cnt_d = drop_cnt_q;
      // The pending mask reloads whenever a different flit becomes the head.
      if (retire) begin
         if (occ_q == 2'd2)
            pending_d = mask_q[~rd_ptr_q];
         else if (push)
            pending_d = bus.in_mask;
         else
            pending_d = '0;
      end else if (!head_present && push) begin
         pending_d = bus.in_mask;
      end
      if (drop && drop_cnt_q != 8'hFF)
         drop_cnt_d = drop_cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            flit_q[i] <= '0;
            mask_q[i] <= '0;
         end
         rd_ptr_q   <= 1'b0;
         wr_ptr_q   <= 1'b0;
         occ_q      <= 2'd0;
         pending_q  <= '0;
         drop_cnt_q <= 8'd0;
      end else begin
         if (push) begin
            flit_q[wr_ptr_q] <= bus.in;
            mask_q[wr_ptr_q] <= bus.in_mask;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (retire)
            rd_ptr_q <= ~rd_ptr_q;
         occ_q      <= occ_d;
         pending_q  <= pending_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end
endmodule

// File: doc/multicast_fanout.md
# multicast_fanout

Broadcast/multicast replication stage of the MPI collective router, the opposite direction of the reduction fan-in. It accepts one flit plus a destination port mask per handshake and delivers that flit to every masked output port. Each output port has its own valid/avail handshake, so slow ports never block fast ones. A flit retires only after all its masked ports have taken it. A 2-entry buffer decouples the upstream crossbar from output back-pressure.

## Interface
- FAN_OUT, 6, number of output ports (PORT_NUM)
- ValidBitPos, 81, bit index of the flit valid bit
- lg_numprocs, 3, log2 of processor count
- FlitWidth, ValidBitPos+1 (82), flit payload width
- ChildrenWidth, lg_numprocs (3), children field width
- FlitChildWidth, FlitWidth+ChildrenWidth (85), width of one flit-with-children word

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset. Asynchronous, active-low: rst=0 clears all state immediately.
- in  in  FlitChildWidth  flit to replicate
- in_mask  in  FAN_OUT  destination ports, bit i selects port i
- in_valid  in  1  upstream flit present
- in_avail  out  1  block can accept a flit this cycle
- out  out  FlitChildWidth*FAN_OUT  per-port flit. Port i occupies [i*FlitChildWidth +: FlitChildWidth].
- out_valid  out  FAN_OUT  per-port valid
- out_avail  in  FAN_OUT  per-port downstream ready
- drop_cnt  out  8  saturating count of zero-mask flits discarded

## Operation
- **Input handshake.** A transfer occurs on a rising edge with in_valid=1 and in_avail=1.
  - in_avail = (occupancy < 2).
  - in_avail is derived from registers only. There is no combinational path from out_avail or in_valid.
- **Zero-mask flits.** A flit accepted with in_mask=0 is not stored. drop_cnt increments and saturates at 255.
- **Buffer.** 2-entry FIFO of {flit, mask}, with rd_ptr, wr_ptr and a 2-bit occupancy counter. Pointers wrap modulo 2.
- **Head pending mask.** `pending` (FAN_OUT bits) is loaded with the mask of the new head whenever the head changes:
  - on a push into an empty FIFO;
  - on a retire when occupancy is 2 (loads the second entry's mask).
- **Output drive.**
  - out_valid[i] = head_present & pending[i].
  - Every port slice of `out` carries the head flit unmodified; the children field is not rewritten.
  - When no head is present, `out` is 0.
- **Output handshake.** Port i transfers on an edge with out_valid[i]=1 and out_avail[i]=1; pending[i] is then cleared.
  - Several ports may transfer on the same edge.
  - out_avail[i] while out_valid[i]=0 has no effect.
- **Retire.** When pending & ~(out_valid & out_avail) == 0 on an edge, the head pops on that edge. If a second entry exists, it becomes the head with no bubble.
- **Simultaneous push and retire.** Both take effect on the same edge:
  - occupancy is unchanged;
  - if occupancy was 1, the pushed flit becomes the head immediately, with its mask loaded into `pending`.
- **Full.** At occupancy 2, in_avail=0. A retire on the same edge does not allow a same-cycle push.
- **Reset mid-operation.** Buffered flits and pending deliveries are discarded. Partially delivered multicasts are not completed.

## Timing
- **Reset values.** in_avail=1, out_valid=0, out=0, drop_cnt=0, occupancy=0, pending=0.
- **Latency.** A flit accepted at edge N with an empty FIFO drives out_valid from cycle N+1, i.e. after edge N.
- **Throughput.** 1 flit/cycle when every masked port holds out_avail=1 continuously.
- **Residency.** Minimum 1 cycle per flit. Maximum is unbounded and set by the slowest masked port.
- **Independence.** A port's completion depends only on its own out_avail.

## Test plan
- **Reset check.** Assert rst=0 for 3 cycles, then release -> in_avail=1, out_valid=6'b000000, drop_cnt=0.
- **Single multicast.** in=85'h1A5, in_mask=6'b101001, all out_avail=1.
  - Required: out_valid=6'b101001 for exactly 1 cycle, starting the cycle after acceptance.
  - Required: the port 0, 3 and 5 slices each equal 85'h1A5.
- **Staggered ports.** in_mask=6'b000111, out_avail=6'b000001 at cycle 1, 6'b000010 at cycle 2, 6'b000100 at cycle 3.
  - Required: out_valid goes 6'b000111 -> 6'b000110 -> 6'b000100 -> 6'b000000.
  - Required: the flit retires at cycle 3.
- **Full buffer.** All out_avail=0; push flits A (mask 6'b000001) and B (mask 6'b000010).
  - Required: in_avail=0 after the second push, and a third in_valid is not accepted.
  - Raise out_avail[0] for 1 cycle -> A retires, B's out_valid=6'b000010 the next cycle, in_avail returns to 1.
- **Zero mask.** Accept 300 flits with in_mask=0 -> out_valid stays 0, drop_cnt=255 (saturated), in_avail stays 1.
- **Reset mid-multicast.** Head has pending=6'b110000; assert rst=0 asynchronously mid-cycle.
  - Required: out_valid=0 immediately, without waiting for a clock edge.
  - Required: after release, occupancy=0 and the flit is never re-sent.
